// File: rtl/riscv_dmem_tcm.sv
// riscv_dmem_tcm: single-port tightly-coupled data memory with a fixed-latency response pipeline
package riscv_dmem_tcm_pkg;
  typedef enum logic [2:0] {
    BYTE       = 3'b000,
    HWORD      = 3'b001,
    WORD       = 3'b010,
    DWORD      = 3'b011,
    UNDEF_SIZE = 3'b111
  } biu_size_t;
endpackage

module riscv_dmem_tcm
  import riscv_dmem_tcm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dmem_req_i,
  input  logic            dmem_lock_i,
  input  logic            dmem_we_i,
  input  biu_size_t       dmem_size_i,
  input  logic [XLEN-1:0] dmem_adr_i,
  input  logic [XLEN-1:0] dmem_d_i,
  output logic            dmem_ack_o,
  output logic [XLEN-1:0] dmem_q_o,
  output logic            dmem_misaligned_o,
  output logic            dmem_page_fault_o
);
  localparam int SB = XLEN / 8;
  localparam int OW = $clog2(SB);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic            vld;
    logic            mis;
    logic            pf;
    logic [XLEN-1:0] dat;
  } rsp_t;

  logic [XLEN-1:0] mem_q [DEPTH];
  rsp_t            rsp_q [LATENCY];
  rsp_t            rsp_d;
  logic            rdy_q;
  logic            acc, mis, oor, wr, rd;
  logic [IW-1:0]   idx;
  logic [OW-1:0]   off;
  logic [7:0]      base;
  logic [SB-1:0]   be;
  logic            unused;

  assign unused = dmem_lock_i;

  // decode request: word index, alignment, range, byte enables and the stage-0 response
  always_comb begin
    acc   = dmem_req_i & rdy_q;
    idx   = dmem_adr_i[OW +: IW];
    off   = dmem_adr_i[OW-1:0];
    oor   = |(dmem_adr_i >> (OW + IW));
    mis   = dmem_size_i == BYTE  ? 1'b0 :
            dmem_size_i == HWORD ? dmem_adr_i[0] :
            dmem_size_i == WORD  ? |dmem_adr_i[1:0] :
            dmem_size_i == DWORD ? (XLEN == 32 ? 1'b1 : |dmem_adr_i[2:0]) : 1'b1;
    base  = dmem_size_i == BYTE  ? 8'h01 :
            dmem_size_i == HWORD ? 8'h03 :
            dmem_size_i == WORD  ? 8'h0f : 8'hff;
    be    = SB'(base) << off;
    wr    = acc & dmem_we_i & ~mis & ~oor;
    rd    = acc & ~dmem_we_i & ~mis & ~oor;
    rsp_d.vld = acc;
    rsp_d.mis = acc & mis;
    rsp_d.pf  = acc & ~mis & oor;
    rsp_d.dat = rd ? mem_q[idx] : '0;
  end

  // byte-lane masked write into the array on the accept edge; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr)
      for (int b = 0; b < SB; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= dmem_d_i[8*b +: 8];
  end

  // response shift register; rdy_q drops the request sampled on the first edge after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q <= 1'b0;
      for (int k = 0; k < LATENCY; k++) rsp_q[k] <= '0;
    end else begin
      rdy_q    <= 1'b1;
      rsp_q[0] <= rsp_d;
      for (int k = 1; k < LATENCY; k++) rsp_q[k] <= rsp_q[k-1];
    end
  end

  assign dmem_ack_o        = rsp_q[LATENCY-1].vld;
  assign dmem_misaligned_o = rsp_q[LATENCY-1].mis;
  assign dmem_page_fault_o = rsp_q[LATENCY-1].pf;
  assign dmem_q_o          = rsp_q[LATENCY-1].dat;
endmodule

// File: doc/riscv_dmem_tcm.md
# riscv_dmem_tcm

Tightly-coupled data memory that responds to the core's data-memory request interface issued by the load/store unit. It accepts one single-cycle request per clock, performs byte-lane-masked writes or full-word reads on an internal synchronous array, and returns acknowledge, read data and error flags after a fixed pipelined latency. It sits between the LSU's dmem port and the write-back stage. It replaces an external bus for simulation and for small embedded configurations.

## Interface
- XLEN, 32, data/address width; 32 or 64 only.
- DEPTH, 1024, array size in XLEN-wide words; power of two.
- LATENCY, 1, request-to-ack cycles; legal range 1..4.

- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- dmem_req_i  input  1  request valid, one cycle per access.
- dmem_lock_i  input  1  locked-access hint; accepted, no effect in this block.
- dmem_we_i  input  1  1 = store, 0 = load.
- dmem_size_i  input  biu_size_t  access size (BYTE/HWORD/WORD/DWORD/UNDEF_SIZE).
- dmem_adr_i  input  XLEN  byte address.
- dmem_d_i  input  XLEN  store data, already shifted onto its byte lanes.
- dmem_ack_o  output  1  response valid, one cycle per request.
- dmem_q_o  output  XLEN  read data, full aligned word.
- dmem_misaligned_o  output  1  request was misaligned or had an illegal size.
- dmem_page_fault_o  output  1  request address outside the array.

## Operation
- No backpressure: a request is accepted in every cycle that dmem_req_i=1; back-to-back requests are legal.
- Word index = dmem_adr_i >> log2(XLEN/8). Lane offset = low log2(XLEN/8) address bits.
- Misaligned conditions:
  - HWORD with adr[0]=1.
  - WORD with adr[1:0]≠0.
  - DWORD with XLEN=32, or with adr[2:0]≠0 when XLEN=64.
  - UNDEF_SIZE in any case.
- Out of range: word index ≥ DEPTH, meaning any nonzero address bit above the index field.
- Error precedence: if misaligned, only dmem_misaligned_o is set. dmem_page_fault_o is set only for an aligned, out-of-range request.
- Stores:
  - Byte-enable is size-wide (1/2/4/8 bytes), starting at the lane offset.
  - Only enabled lanes of dmem_d_i are written.
  - The write commits on the accept edge.
  - No write occurs on any error.
- Loads:
  - The array is read on the accept edge and returns the entire word, with no shifting or sign extension (the write-back stage extracts).
  - q=0 on any error.
- Stores also produce an ack. q is 0 for stores.
- Response pipeline: a LATENCY-deep shift register of {valid, misaligned, page_fault, data}. Stage 0 is loaded on the accept edge. The last stage drives the outputs.
- Array contents are not reset.

## Timing
- Reset values: dmem_ack_o=0, dmem_q_o=0, dmem_misaligned_o=0, dmem_page_fault_o=0. All pipeline valid bits are 0.
- A request sampled at edge N produces dmem_ack_o=1 for exactly one cycle after edge N+LATENCY-1. LATENCY=1 means ack is visible in the cycle following the request.
- Throughput is one response per cycle. Responses are returned in request order with no gaps added or removed.
- Error flags and q are valid only while dmem_ack_o=1. They are 0 when ack=0.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data. A load in the same cycle as a store is impossible (single port, one request per cycle).
- Reset asserted mid-operation:
  - All in-flight responses are discarded and no ack is emitted for them.
  - Stores already accepted before the reset edge remain in the array.
  - A request presented in the cycle reset is released is ignored.
- Requests with X on dmem_size_i or dmem_adr_i while dmem_req_i=0 have no effect.

## Test plan
- XLEN=32, LATENCY=1: store WORD 0xDEADBEEF at 0x10, then load WORD at 0x10 on the next cycle -> ack one cycle after each request; load q=0xDEADBEEF; no flags.
- Store BYTE at 0x13 with d=0xAA000000 onto a word holding 0x11223344, then load 0x10 -> q=0xAA223344.
- Load HWORD at 0x21 -> ack with dmem_misaligned_o=1, q=0. Store WORD at 0x22 -> misaligned=1 and word 0x20 is unchanged on readback.
- DEPTH=1024, load WORD at 0x1000 -> dmem_page_fault_o=1, misaligned=0, q=0. Load HWORD at 0x1001 -> misaligned=1, page_fault=0.
- LATENCY=3: four back-to-back loads at 0x0, 0x4, 0x8, 0xC -> four consecutive acks starting 3 cycles after the first request, with data in order.
- LATENCY=3: issue 2 loads, assert rst_ni low the next cycle -> no acks ever emitted and all outputs 0. A store accepted before reset reads back correctly after reset.
